frame_assembler: RTL and testbench

FRAME_ASSEMBLER -- requirements
Module: frame_assembler

---
 rtl/image_pkg.sv | 17 +
 rtl/pixel_position_counter.sv | 55 +++++
 rtl/frame_assembler.sv | 96 +++++++++
 tb/tb_frame_assembler.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// image_pkg: shared image geometry defaults, assembler FSM encoding and slot helper
package image_pkg;
    localparam int IMAGE_HEIGHT = 4;
    localparam int IMAGE_WIDTH  = 4;
    localparam int DATA_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } fa_state_e;

    // Slot 0 sits in the MSB byte so the downstream serializer can shift MSB-first
    function automatic int slot_msb(input int n, input int k);
        return 8 * (n - k) - 1;
    endfunction
endpackage

// File: rtl/pixel_position_counter.sv
// pixel_position_counter: row-major row/col/slot index tracker for the frame assembler
module pixel_position_counter #(
    parameter int imageheight = 4,
    parameter int imageWidth  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        advance,
    output logic [15:0] row,
    output logic [15:0] col,
    output logic [15:0] index,
    output logic        last
);
    localparam int N = imageheight * imageWidth;

    logic [15:0] row_q, col_q, idx_q;
    logic [15:0] row_d, col_d, idx_d;
    logic [15:0] row_b, col_b, idx_b;
    logic        col_end;

    // clear rebases to slot 0 before an advance in the same cycle consumes it
    always_comb begin
        row_b   = clear ? 16'd0 : row_q;
        col_b   = clear ? 16'd0 : col_q;
        idx_b   = clear ? 16'd0 : idx_q;
        col_end = col_b == 16'(imageWidth - 1);
        row_d   = row_b;
        col_d   = col_b;
        idx_d   = idx_b;
        if (advance) begin
            col_d = col_end ? 16'd0 : col_b + 16'd1;
            row_d = !col_end ? row_b : (row_b == 16'(imageheight - 1)) ? 16'd0 : row_b + 16'd1;
            idx_d = (idx_b == 16'(N - 1)) ? 16'd0 : idx_b + 16'd1;
        end
    end

    // position registers; wrap past the last slot lands back on 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end

    assign row   = row_q;
    assign col   = col_q;
    assign index = idx_q;
    assign last  = idx_q == 16'(N - 1);
endmodule

// File: rtl/frame_assembler.sv
// frame_assembler: packs a pixel byte stream into a full frame word held until ack;
// optional frame checksum enabled by defining FRAME_CHECKSUM_EN
module frame_assembler #(
    parameter int imageheight = image_pkg::IMAGE_HEIGHT,
    parameter int imageWidth  = image_pkg::IMAGE_WIDTH,
    parameter int data_width  = image_pkg::DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                pix_valid,
    input  logic                                pix_sof,
    input  logic [data_width-1:0]               pix_data,
    output logic                                pix_ready,
    input  logic                                frame_ack,
    output logic [8*imageheight*imageWidth-1:0] frame_data,
    output logic                                frame_valid,
    output logic [15:0]                         row,
    output logic [15:0]                         col,
    output logic                                sof_err,
    output logic [15:0]                         frame_sum
);
    import image_pkg::*;

    localparam int N = imageheight * imageWidth;

    fa_state_e          state_q;
    logic               pix_ready_q, frame_valid_q, sof_err_q;
    logic [8*N-1:0]     frame_q;
    logic [15:0]        index, slot;
    logic               last, accept, wr, done;

    assign accept = pix_valid & pix_ready_q;
    assign wr     = accept & (pix_sof | (state_q == FILL));
    assign slot   = pix_sof ? 16'd0 : index;
    assign done   = wr & (pix_sof ? (N == 1) : last);

    pixel_position_counter #(
        .imageheight(imageheight),
        .imageWidth (imageWidth)
    ) u_pos (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept & pix_sof),
        .advance(wr),
        .row    (row),
        .col    (col),
        .index  (index),
        .last   (last)
    );

    // FSM with registered handshake/status outputs and frame storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pix_ready_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            sof_err_q     <= 1'b0;
            frame_q       <= '0;
        end else begin
            sof_err_q <= sof_err_q | (accept & (pix_sof ? (state_q == FILL) : (state_q == IDLE)));
            if (wr)
                frame_q[slot_msb(N, int'(slot)) -: 8] <= pix_data[7:0];
            case (state_q)
                HOLD: if (frame_ack) begin
                    state_q       <= IDLE;
                    frame_valid_q <= 1'b0;
                    pix_ready_q   <= 1'b1;
                end
                default: begin
                    if (wr) state_q <= done ? HOLD : FILL;
                    frame_valid_q <= done;
                    pix_ready_q   <= !done;
                end
            endcase
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] sum_q;

    // running byte sum restarted by every accepted start-of-frame byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  sum_q <= '0;
        else if (wr) sum_q <= (pix_sof ? 16'd0 : sum_q) + 16'(pix_data[7:0]);
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = 16'd0;
`endif

    assign pix_ready   = pix_ready_q;
    assign frame_valid = frame_valid_q;
    assign sof_err     = sof_err_q;
    assign frame_data  = frame_q;
endmodule

// File: tb/tb_frame_assembler.sv
// tb_frame_assembler: directed checks of frame_assembler at 2x3 geometry
module tb_frame_assembler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_ready;
    logic        frame_ack = 1'b0;
    logic [47:0] frame_data;
    logic        frame_valid;
    logic [15:0] row, col;
    logic        sof_err;
    logic [15:0] frame_sum;

    int tests = 0;
    int fails = 0;

    frame_assembler #(.imageheight(2), .imageWidth(3), .data_width(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .frame_ack  (frame_ack),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .row        (row),
        .col        (col),
        .sof_err    (sof_err),
        .frame_sum  (frame_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic s, input logic [7:0] d);
        pix_valid = 1'b1;
        pix_sof   = s;
        pix_data  = d;
        @(negedge clk);
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(frame_valid), 64'h0);
        check("rst_ready", 64'(pix_ready), 64'h0);
        check("rst_pos", {32'(row), 32'(col)}, 64'h0);
        check("rst_err", 64'(sof_err), 64'h0);
        check("rst_data", 64'(frame_data), 64'h0);
        check("rst_sum", 64'(frame_sum), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready_after", 64'(pix_ready), 64'h1);
    endtask

    logic [15:0] sum_a, sum_b, sum_c;
    logic [15:0] exp_col [5] = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1};
    logic [15:0] exp_row [5] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1};

    initial begin
`ifdef FRAME_CHECKSUM_EN
        sum_a = 16'h0015;
        sum_b = 16'h0075;
        sum_c = 16'h00D5;
`else
        sum_a = 16'h0000;
        sum_b = 16'h0000;
        sum_c = 16'h0000;
`endif
        #2;
        do_reset();

        push(1'b1, 8'h01);
        for (int i = 2; i <= 5; i++) push(1'b0, 8'(i));
        check("pre_last_valid", 64'(frame_valid), 64'h0);
        push(1'b0, 8'h06);
        check("f1_valid", 64'(frame_valid), 64'h1);
        check("f1_data", 64'(frame_data), 64'h010203040506);
        check("f1_pos", {32'(row), 32'(col)}, 64'h0);
        check("f1_ready", 64'(pix_ready), 64'h0);
        check("f1_sum", 64'(frame_sum), 64'(sum_a));
        check("f1_err", 64'(sof_err), 64'h0);

        for (int i = 0; i < 5; i++) push(1'b1, 8'h77);
        check("hold_ready", 64'(pix_ready), 64'h0);
        check("hold_data", 64'(frame_data), 64'h010203040506);
        check("hold_valid", 64'(frame_valid), 64'h1);
        ack();
        check("ack_valid", 64'(frame_valid), 64'h0);
        check("ack_ready", 64'(pix_ready), 64'h1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("idle_ack_ready", 64'(pix_ready), 64'h1);

        push(1'b0, 8'h55);
        idle();
        check("drop_err", 64'(sof_err), 64'h1);
        check("drop_pos", {32'(row), 32'(col)}, 64'h0);
        check("drop_valid", 64'(frame_valid), 64'h0);

        do_reset();
        push(1'b1, 8'hAA);
        push(1'b0, 8'hBB);
        check("pre_restart_col", 64'(col), 64'h2);
        check("pre_restart_err", 64'(sof_err), 64'h0);
        push(1'b1, 8'h11);
        check("restart_col", 64'(col), 64'h1);
        check("restart_err", 64'(sof_err), 64'h1);
        for (int i = 8'h12; i <= 8'h16; i++) push(1'b0, 8'(i));
        check("f2_data", 64'(frame_data), 64'h111213141516);
        check("f2_valid", 64'(frame_valid), 64'h1);
        check("f2_sum", 64'(frame_sum), 64'(sum_b));
        ack();

        push(1'b1, 8'h21);
        push(1'b0, 8'h22);
        push(1'b0, 8'h23);
        pix_valid = 1'b0;
        do_reset();
        for (int i = 8'h21; i <= 8'h26; i++) push(i == 8'h21, 8'(i));
        check("f3_data", 64'(frame_data), 64'h212223242526);
        check("f3_err", 64'(sof_err), 64'h0);
        check("f3_sum", 64'(frame_sum), 64'(sum_c));
        ack();

        for (int k = 0; k < 6; k++) begin
            if (k < 5) check($sformatf("step%0d_pos", k), {32'(row), 32'(col)}, {32'(exp_row[k]), 32'(exp_col[k])});
            push(k == 0, 8'(8'h31 + k));
            idle();
        end
        check("f4_data", 64'(frame_data), 64'h313233343536);
        check("f4_valid", 64'(frame_valid), 64'h1);
        ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
